// File: rtl/shift_add_mult_5b_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   - state_t      : FSM state encodings (IDLE, CALC, DONE)
//   - MULT_WIDTH   : default operand width in bits
package mult_5b_defs;

   localparam int MULT_WIDTH = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : mult_5b_defs

// File: rtl/shift_add_mult_5b_rca.sv
// Parameterised WIDTH-bit ripple-carry adder built from 1-bit full-adder cells.
// Ports:
//   a, b  : WIDTH-bit addends
//   cin   : carry into bit 0
//   s     : WIDTH-bit sum
//   cout  : carry out of the most significant cell
module rca_nb #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   // carry_s[i] is the carry into cell i; carry_s[WIDTH] is the final carry out
   logic [WIDTH:0] carry_s;

   assign carry_s[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s[i]         = a[i] ^ b[i] ^ carry_s[i];
      assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
   end

   assign cout = carry_s[WIDTH];

endmodule : rca_nb

// File: rtl/shift_add_mult_5b.sv
// Sequential unsigned shift-and-add multiplier, one ripple-carry add per clock.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (highest priority)
//   start  : request a*b; sampled only when not busy (IDLE or DONE)
//   a, b   : WIDTH-bit multiplicand / multiplier, captured on the accepting edge
//   busy   : high while the FSM is in CALC
//   done   : one-cycle pulse, p valid while high
//   p      : 2*WIDTH-bit product, held until the next completion
module shift_add_mult_5b
   import mult_5b_defs::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state_r;
   state_t             state_s;
   logic [WIDTH-1:0]   m_r;
   logic [WIDTH-1:0]   q_r;
   logic [WIDTH-1:0]   acc_r;
   logic               c_r;
   logic [CNT_W-1:0]   count_r;
   logic [2*WIDTH-1:0] p_r;
   logic               busy_r;
   logic               done_r;

   logic [WIDTH-1:0]   sum_s;
   logic               cout_s;
   logic [WIDTH-1:0]   acc_add_s;
   logic               c_add_s;
   logic [WIDTH-1:0]   acc_sh_s;
   logic [WIDTH-1:0]   q_sh_s;
   logic               last_s;
   logic               busy_s;
   logic               done_s;

   rca_nb #(.WIDTH(WIDTH)) u_rca (
      .a    (acc_r),
      .b    (m_r),
      .cin  (1'b0),
      .s    (sum_s),
      .cout (cout_s)
   );

   // One iteration: conditional add of M, then shift {C,A,Q} right by one
   always_comb begin
      acc_add_s = acc_r;
      c_add_s   = c_r;
      if (q_r[0]) begin
         acc_add_s = sum_s;
         c_add_s   = cout_s;
      end else begin
         // c_r is always zero here: load clears it and every shift inserts 0
         acc_add_s = acc_r;
         c_add_s   = c_r;
      end
      acc_sh_s = {c_add_s, acc_add_s[WIDTH-1:1]};
      q_sh_s   = {acc_add_s[0], q_r[WIDTH-1:1]};
      last_s   = (count_r == CNT_W'(WIDTH - 1));
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; unused encodings recover to IDLE
   always_comb begin
      state_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_CALC;
            else       state_s = ST_IDLE;
         end
         ST_CALC: begin
            if (last_s) state_s = ST_DONE;
            else        state_s = ST_CALC;
         end
         ST_DONE: begin
            if (start) state_s = ST_CALC;
            else       state_s = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // FSM output decode from the next state so the flops track the state register
   always_comb begin
      busy_s = (state_s == ST_CALC);
      done_s = (state_s == ST_DONE);
   end

   // Registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_s;
         done_r <= done_s;
      end
   end

   // Datapath registers: operand capture, iteration, product update
   always_ff @(posedge clk) begin
      if (rst) begin
         m_r     <= '0;
         q_r     <= '0;
         acc_r   <= '0;
         c_r     <= 1'b0;
         count_r <= '0;
         p_r     <= '0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  m_r     <= a;
                  q_r     <= b;
                  acc_r   <= '0;
                  c_r     <= 1'b0;
                  count_r <= '0;
               end
            end
            ST_CALC: begin
               acc_r   <= acc_sh_s;
               q_r     <= q_sh_s;
               c_r     <= 1'b0;
               count_r <= count_r + CNT_W'(1);
               if (last_s) begin
                  p_r <= {acc_sh_s, q_sh_s};
               end
            end
            default: begin
               count_r <= '0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign p    = p_r;

endmodule : shift_add_mult_5b

// File: doc/shift_add_mult_5b.md
Name: shift_add_mult_5b

Overview:
- Sequential unsigned shift-and-add multiplier: one WIDTH-bit ripple-carry add per clock.
- Sits downstream of the 5-bit ripple-carry adder stage and consumes its sum/carry as its datapath adder.
- Feeds the lab datapath with a 2*WIDTH-bit product behind a start/busy/done handshake.

Parameters:
- WIDTH, 5, operand width in bits. Product is 2*WIDTH bits; the iteration counter is sized to hold WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to multiply a by b. Sampled only when the block is not busy.
- a  input  WIDTH  multiplicand, captured on the accepting edge.
- b  input  WIDTH  multiplier, captured on the accepting edge.
- busy  output  1  high while state is CALC.
- done  output  1  one-cycle pulse; p is valid when high.
- p  output  2*WIDTH  product register. Holds its last result until the next completion.

Behaviour:
- Reset (rst high at a rising edge): state=IDLE; busy=0, done=0, p=0; internal M, Q, A, C and count all cleared. Reset has priority over every other input.
- States: IDLE, CALC, DONE.
- IDLE or DONE with start=1:
  - go to CALC; M<=a, Q<=b, A<=0, C<=0, count<=0.
  - done falls on this edge.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE. done is therefore high for exactly one cycle.
- CALC, each edge (one iteration):
  - {C,A} = Q[0] ? A+M (adder, CIN=0) : {0,A}.
  - Then {C,A,Q} <= ({C,A,Q}) >> 1.
  - count <= count+1.
- On the edge where count==WIDTH-1:
  - state<=DONE; p<={A,Q} using the post-shift values.
  - busy falls and done rises on the same edge.
- Latency:
  - start sampled at edge E0.
  - busy is high from E0 to E0+WIDTH.
  - done is high for the cycle between edges E0+WIDTH and E0+WIDTH+1. For WIDTH=5 this is 5 cycles after acceptance.
- start while in CALC: ignored. The operation is not restarted and the request is not queued.
- start held high continuously: accepted in IDLE and again in DONE. This gives back-to-back operations of WIDTH+1 cycles each.
- a and b may change freely after the accepting edge; the result uses the captured values.
- p keeps its previous value during CALC and updates only on the completing edge.
- Arithmetic: unsigned only. The carry out of the adder is kept in C and shifted into A. No overflow is possible: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Reset mid-CALC: abort. Same outputs as reset (p=0, no done pulse).
- Unused state encoding: go to IDLE on the next edge.

Decomposition:
- Package mult_5b_defs:
  - state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - default WIDTH constant.
- One sub-module, rca_nb: parameterised WIDTH-bit ripple-carry adder (a, b, cin -> s, cout) built from 1-bit full-adder cells. The multiplier instantiates it once with cin tied to 0.
- FSM, counter and shift registers stay in shift_add_mult_5b.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1, a=31, b=31 -> busy=0, done=0, p=0 throughout; no operation starts.
- Boundary: a=31, b=31, start pulsed at E0 -> busy high E0..E0+5; done high for exactly one cycle after E0+5; p=961 (10'b1111000001).
- Basic results:
  - a=21, b=10 -> p=210.
  - a=1, b=31 -> p=31.
  - a=0, b=27 -> p=0. done still pulses, with the same latency.
- Back-to-back: start held high with a=3, b=7, then a=31, b=2 presented at the DONE cycle -> p=21, then p=62, with done pulses 6 cycles apart. A start pulsed mid-CALC is ignored: p stays 21 and no extra done appears.
- Reset mid-op: a=25, b=25, rst asserted at E0+3 -> next cycle busy=0, p=0; done never pulses. A new start with a=2, b=3 after reset yields p=6.
- Operand stability: change a and b every cycle during CALC after capturing a=13, b=11 -> p=143.
